// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, on-the-fly key expansion, ten rounds on a shared datapath.
// Optional feature macro AES_KEY_REUSE_EN adds key_reuse_i to encrypt with the previously loaded cipher key.
module aes128_round_ctrl #(
  parameter int ROUND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_i,
  input  logic [127:0] key_i,
`ifdef AES_KEY_REUSE_EN
  input  logic         key_reuse_i,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_o,
  output logic         busy_o,
  output logic [3:0]   round_o,
  output logic         rd_valid_o,
  output logic [127:0] rd_data_o,
  output logic [127:0] rd_key_o,
  output logic         rd_final_o,
  input  logic [127:0] rd_data_i
);

  localparam int WCW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [WCW-1:0] WCNT_LOAD = WCW'(ROUND_LAT - 1);
  localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);
  localparam logic [WCW-1:0] WCNT_ZERO = WCW'(0);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         r_state;
  logic [127:0]   r_pt;
  logic [127:0]   r_rkey;
  logic [WCW-1:0] r_wcnt;
  logic [127:0]   w_next_key;
  logic [127:0]   w_load_key;
`ifdef AES_KEY_REUSE_EN
  logic [127:0]   r_orig_key;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // round_o is 0 in INIT, so round_o+1 selects rcon[1] there and rcon[r+1] after round r
  assign w_next_key = expand_key(r_rkey, rcon_of(round_o + 4'd1));

`ifdef AES_KEY_REUSE_EN
  assign w_load_key = key_reuse_i ? r_orig_key : key_i;
`else
  assign w_load_key = key_i;
`endif

  // Sequencer FSM with all handshake and datapath outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pt       <= 128'h0;
      r_rkey     <= 128'h0;
      r_wcnt     <= WCNT_ZERO;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      ct_o       <= 128'h0;
      busy_o     <= 1'b0;
      round_o    <= 4'd0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= 128'h0;
      rd_key_o   <= 128'h0;
      rd_final_o <= 1'b0;
`ifdef AES_KEY_REUSE_EN
      r_orig_key <= 128'h0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pt     <= pt_i;
            r_rkey   <= w_load_key;
`ifdef AES_KEY_REUSE_EN
            r_orig_key <= w_load_key;
`endif
            in_ready <= 1'b0;
            busy_o   <= 1'b1;
            r_state  <= S_INIT;
          end
        end
        S_INIT: begin
          r_rkey     <= w_next_key;
          round_o    <= 4'd1;
          rd_valid_o <= 1'b1;
          rd_data_o  <= r_pt ^ r_rkey;
          rd_key_o   <= w_next_key;
          rd_final_o <= 1'b0;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          rd_valid_o <= 1'b0;
          r_wcnt     <= WCNT_LOAD;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt != WCNT_ZERO) begin
            r_wcnt <= r_wcnt - WCNT_ONE;
          end else if (round_o == 4'd10) begin
            out_valid <= 1'b1;
            ct_o      <= rd_data_i;
            r_state   <= S_DONE;
          end else begin
            r_rkey     <= w_next_key;
            round_o    <= round_o + 4'd1;
            rd_valid_o <= 1'b1;
            rd_data_o  <= rd_data_i;
            rd_key_o   <= w_next_key;
            rd_final_o <= (round_o == 4'd9);
            r_state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy_o    <= 1'b0;
            round_o   <= 4'd0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          in_ready   <= 1'b1;
          busy_o     <= 1'b0;
          round_o    <= 4'd0;
          rd_valid_o <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for aes128_round_ctrl: two instances (ROUND_LAT 1 and 3) each driving a behavioural AES round datapath.
module tb_aes128_round_ctrl;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_K1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] B_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] JUNK    = {4{32'hdeadbeef}};

  typedef struct {
    int           id;
    logic [127:0] ct;
    logic [127:0] k1;
    logic [127:0] k10;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  logic [7:0] sb [256];

  logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1, busy_a, rd_valid_a, rd_final_a;
  logic [127:0] pt_a = 128'h0, key_a = 128'h0, ct_a, rd_data_a, rd_key_a, rd_in_a;
  logic [3:0]   round_a;
  logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, busy_b, rd_valid_b, rd_final_b;
  logic [127:0] pt_b = 128'h0, key_b = 128'h0, ct_b, rd_data_b, rd_key_b, rd_in_b;
  logic [3:0]   round_b;
`ifdef AES_KEY_REUSE_EN
  logic         reuse_a = 1'b0;
  logic         reuse_b = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_round_ctrl #(.ROUND_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .pt_i(pt_a), .key_i(key_a),
`ifdef AES_KEY_REUSE_EN
    .key_reuse_i(reuse_a),
`endif
    .out_valid(out_valid_a), .out_ready(out_ready_a), .ct_o(ct_a), .busy_o(busy_a),
    .round_o(round_a), .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .rd_key_o(rd_key_a),
    .rd_final_o(rd_final_a), .rd_data_i(rd_in_a)
  );

  aes128_round_ctrl #(.ROUND_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .pt_i(pt_b), .key_i(key_b),
`ifdef AES_KEY_REUSE_EN
    .key_reuse_i(reuse_b),
`endif
    .out_valid(out_valid_b), .out_ready(out_ready_b), .ct_o(ct_b), .busy_o(busy_b),
    .round_o(round_b), .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b), .rd_key_o(rd_key_b),
    .rd_final_o(rd_final_b), .rd_data_i(rd_in_b)
  );

  // S-box built by walking the generator 3 and its inverse
  task automatic init_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) a[n] = sb[s[127-8*n -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = fin ? b[n] : m[n];
    return o ^ k;
  endfunction

  // Round datapath models: result only during the final latency cycle, junk otherwise
  logic [127:0] pend_a, pend_b;
  int cd_a = 0, cd_b = 0;
  always @(posedge clk) begin
    if (rd_valid_a) begin pend_a <= aes_round(rd_data_a, rd_key_a, rd_final_a); cd_a <= 1; end
    else if (cd_a != 0) cd_a <= cd_a - 1;
    if (rd_valid_b) begin pend_b <= aes_round(rd_data_b, rd_key_b, rd_final_b); cd_b <= 3; end
    else if (cd_b != 0) cd_b <= cd_b - 1;
  end
  assign rd_in_a = (cd_a == 1) ? pend_a : JUNK;
  assign rd_in_b = (cd_b == 1) ? pend_b : JUNK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   t0_m [2];
  int   pulses_m [2];
  int   rise_m [2];
  logic prev_ov_m [2];

  task automatic mon_step(input int id, input int lat, input logic iv, input logic ir,
                          input logic ov, input logic ordy, input logic rv, input logic fin,
                          input logic [3:0] rnd, input logic [127:0] rk, input logic [127:0] ct);
    exp_t e;
    if (!rst_n) begin
      prev_ov_m[id] = 1'b0;
      pulses_m[id]  = 0;
    end else begin
      if (rv) begin
        pulses_m[id]++;
        check_int("rd_final", int'(fin), (pulses_m[id] == 10) ? 1 : 0);
        check_int("round_o", int'(rnd), pulses_m[id]);
        check_int("issue_cycle", cyc - t0_m[id], 2 + (pulses_m[id] - 1) * (1 + lat));
        if (sbq.size() > 0 && pulses_m[id] == 1) check("rkey_r1", rk, sbq[0].k1);
        if (sbq.size() > 0 && pulses_m[id] == 10) check("rkey_r10", rk, sbq[0].k10);
      end
      if (ov && !prev_ov_m[id]) rise_m[id] = cyc;
      prev_ov_m[id] = ov;
      if (ov && ordy) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: inst %0d got %h expected no output", id, ct);
        end else begin
          e = sbq.pop_front();
          check_int("inst_id", id, e.id);
          check("ciphertext", ct, e.ct);
          check_int("out_latency", rise_m[id] - t0_m[id], 2 + 10 * (1 + lat));
          check_int("rd_valid_pulses", pulses_m[id], 10);
        end
      end
      if (iv && ir) begin
        t0_m[id]     = cyc;
        pulses_m[id] = 0;
      end
    end
  endtask

  // Monitor: samples both instances on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      mon_step(0, 1, in_valid_a, in_ready_a, out_valid_a, out_ready_a, rd_valid_a, rd_final_a, round_a, rd_key_a, ct_a);
      mon_step(1, 3, in_valid_b, in_ready_b, out_valid_b, out_ready_b, rd_valid_b, rd_final_b, round_b, rd_key_b, ct_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct, input logic [127:0] k1, input logic [127:0] k10);
    exp_t e;
    int   n;
    e.id = id; e.ct = ct; e.k1 = k1; e.k10 = k10;
    n = 0;
    while (((id == 0) ? !in_ready_a : !in_ready_b) && n < 200) begin tick(); n++; end
    check_int("in_ready_wait", n < 200 ? 1 : 0, 1);
    sbq.push_back(e);
    if (id == 0) begin pt_a = pt; key_a = key; in_valid_a = 1'b1; end
    else begin pt_b = pt; key_b = key; in_valid_b = 1'b1; end
    tick();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    pt_a = JUNK; key_a = JUNK; pt_b = JUNK; key_b = JUNK;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 600) begin tick(); n++; end
    check_int("output_wait", n < 600 ? 1 : 0, 1);
  endtask

  task automatic reset_chk(input string tag, input logic ir, input logic ov, input logic bz,
                           input logic [3:0] rnd, input logic rv, input logic fin,
                           input logic [127:0] ct, input logic [127:0] rdd, input logic [127:0] rdk);
    check({tag, "_in_ready"}, ir, 1);
    check({tag, "_out_valid"}, ov, 0);
    check({tag, "_busy"}, bz, 0);
    check({tag, "_round"}, rnd, 0);
    check({tag, "_rd_valid"}, rv, 0);
    check({tag, "_rd_final"}, fin, 0);
    check({tag, "_ct"}, ct, 0);
    check({tag, "_rd_data"}, rdd, 0);
    check({tag, "_rd_key"}, rdk, 0);
  endtask

  initial begin
    int n;
    init_sbox();
    repeat (2) tick();
    reset_chk("rst_a", in_ready_a, out_valid_a, busy_a, round_a, rd_valid_a, rd_final_a, ct_a, rd_data_a, rd_key_a);
    reset_chk("rst_b", in_ready_b, out_valid_b, busy_b, round_b, rd_valid_b, rd_final_b, ct_b, rd_data_b, rd_key_b);
    rst_n = 1'b1;
    tick();

    send(0, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    wait_done();
    send(0, B_PT, B_KEY, B_CT, B_K1, B_K10);
    wait_done();

    // Backpressure: DONE holds, new offers ignored
    out_ready_a = 1'b0;
    send(0, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    n = 0;
    while (!out_valid_a && n < 100) begin tick(); n++; end
    check_int("done_wait", n < 100 ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_ct", ct_a, C1_CT);
      check("hold_out_valid", out_valid_a, 1);
      check("hold_in_ready", in_ready_a, 0);
      pt_a = B_PT; key_a = B_KEY; in_valid_a = 1'b1;
      tick();
    end
    check("hold_ct_last", ct_a, C1_CT);
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    tick();
    check("release_in_ready", in_ready_a, 1);
    check("release_out_valid", out_valid_a, 0);
    check("release_busy", busy_a, 0);

    // Reset during round 5 WAIT discards the block
    send(0, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    n = 0;
    while (!(round_a == 4'd5 && !rd_valid_a && busy_a) && n < 100) begin tick(); n++; end
    check_int("r5_wait", n < 100 ? 1 : 0, 1);
    rst_n = 1'b0;
    tick();
    reset_chk("midrst_a", in_ready_a, out_valid_a, busy_a, round_a, rd_valid_a, rd_final_a, ct_a, rd_data_a, rd_key_a);
    rst_n = 1'b1;
    void'(sbq.pop_back());
    repeat (3) tick();
    send(0, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    wait_done();

    send(1, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    wait_done();
    send(1, B_PT, B_KEY, B_CT, B_K1, B_K10);
    wait_done();

`ifdef AES_KEY_REUSE_EN
    send(0, C1_PT, C1_KEY, C1_CT, C1_K1, C1_K10);
    wait_done();
    reuse_a = 1'b1;
    send(0, 128'h0, {128{1'b1}}, 128'hc6a13b37878f5b826f4f8162a1c8d879, C1_K1, C1_K10);
    reuse_a = 1'b0;
    wait_done();
`endif

    repeat (30) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
